// File: rtl/decode_stage_pipe.sv
// Registered RV32I decode stage: valid/ready handshake, write-back bypass, immediate generation,
// illegal flagging and flush. Define DECODE_RV32M_EN to accept the RV32M (MUL..REMU) encodings.
module decode_stage_pipe #(
    parameter int          XLEN      = 32,
    parameter int          RF_ADDR_W = 5,
    parameter logic [31:0] NOP_INST  = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [XLEN-1:0]      in_pc,
    output logic [RF_ADDR_W-1:0] rs1_addr,
    output logic [RF_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]      rs1_rdata,
    input  logic [XLEN-1:0]      rs2_rdata,
    input  logic                 wb_wen,
    input  logic [RF_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [31:0]          out_inst,
    output logic [XLEN-1:0]      out_rs1_data,
    output logic [XLEN-1:0]      out_rs2_data,
    output logic [XLEN-1:0]      out_imm,
    output logic [RF_ADDR_W-1:0] out_rd_addr,
    output logic                 out_rd_wen,
    output logic                 out_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic                 dec_legal;
    logic                 use_rs1;
    logic                 use_rs2;
    logic                 dec_wen;
    logic [31:0]          imm32;
    logic [XLEN-1:0]      dec_imm;
    logic                 rd_wen_cap;
    logic [RF_ADDR_W-1:0] rd_cap;
    logic [XLEN-1:0]      rs1_cap;
    logic [XLEN-1:0]      rs2_cap;
    logic [RF_ADDR_W-1:0] held_rs1;
    logic [RF_ADDR_W-1:0] held_rs2;
    logic                 accept;
    logic                 hold;
    logic                 clear;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    always_comb begin
        dec_legal = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        dec_wen   = 1'b0;
        imm32     = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_wen   = 1'b1;
                imm32     = {in_inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                dec_legal = 1'b1;
                dec_wen   = 1'b1;
                imm32     = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                             in_inst[30:21], 1'b0};
            end
            OPC_JALR: begin
                dec_legal = (funct3 == 3'b000);
                use_rs1   = 1'b1;
                dec_wen   = 1'b1;
                imm32     = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OPC_BRANCH: begin
                dec_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                imm32     = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                             in_inst[11:8], 1'b0};
            end
            OPC_LOAD: begin
                dec_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                use_rs1   = 1'b1;
                dec_wen   = 1'b1;
                imm32     = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OPC_STORE: begin
                dec_legal = (funct3 <= 3'b010);
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                imm32     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OPC_OP_IMM: begin
                // Shift-immediates reuse the upper immediate bits as funct7.
                if (funct3 == 3'b001)      dec_legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101) dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else                       dec_legal = 1'b1;
                use_rs1 = 1'b1;
                dec_wen = 1'b1;
                imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OPC_OP: begin
                dec_legal = (funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
`ifdef DECODE_RV32M_EN
                if (funct7 == 7'b0000001) dec_legal = 1'b1;
`endif
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_wen = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign dec_imm    = XLEN'($signed(imm32));
    assign rd_wen_cap = dec_wen && dec_legal;
    assign rd_cap     = rd_wen_cap ? RF_ADDR_W'(in_inst[11:7]) : '0;
    // Illegal entries read nothing, so their operands fall out as zero.
    assign rs1_addr   = (use_rs1 && dec_legal) ? RF_ADDR_W'(in_inst[19:15]) : '0;
    assign rs2_addr   = (use_rs2 && dec_legal) ? RF_ADDR_W'(in_inst[24:20]) : '0;

    assign rs1_cap = (rs1_addr == '0) ? '0 :
                     (wb_wen && (wb_addr == rs1_addr)) ? wb_data : rs1_rdata;
    assign rs2_cap = (rs2_addr == '0) ? '0 :
                     (wb_wen && (wb_addr == rs2_addr)) ? wb_data : rs2_rdata;

    // Handshake: a transfer happens on a side only when its valid and ready are both high
    // at the clock edge; in_ready is high when the register is empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign hold     = out_valid && !out_ready;
    assign clear    = rst || flush || (out_valid && out_ready && !accept);

    always_ff @(posedge clk) begin
        if (clear) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_inst     <= NOP_INST;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_imm      <= '0;
            out_rd_addr  <= '0;
            out_rd_wen   <= 1'b0;
            out_illegal  <= 1'b0;
            held_rs1     <= '0;
            held_rs2     <= '0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_inst     <= in_inst;
            out_rs1_data <= rs1_cap;
            out_rs2_data <= rs2_cap;
            out_imm      <= dec_imm;
            out_rd_addr  <= rd_cap;
            out_rd_wen   <= rd_wen_cap;
            out_illegal  <= !dec_legal;
            held_rs1     <= rs1_addr;
            held_rs2     <= rs2_addr;
        end else if (hold) begin
            // Track write-back so a stalled entry does not carry stale operands.
            if (wb_wen && (held_rs1 != '0) && (wb_addr == held_rs1)) out_rs1_data <= wb_data;
            if (wb_wen && (held_rs2 != '0) && (wb_addr == held_rs2)) out_rs2_data <= wb_data;
        end
    end

endmodule
